axioma_eeprom_ctrl_v2: RTL and testbench

Parametrised ATmega328P-compatible EEPROM controller. Supports a configurable array size, configurable erase/write/read timing, a true 4-cycle EEMPE arming window, a level-type EE_READY interrupt and a CPU halt request. It sits on the I/O bus beside the other peripherals and owns a dedicated byte array sub-module. Array contents survive reset_n; only the registers and FSM are reset.

---
 rtl/axioma_eeprom_pkg.sv | 42 ++++
 rtl/axioma_eeprom_array.sv | 28 ++
 rtl/axioma_eeprom_ctrl_v2.sv | 250 +++++++++++++++++++++++++
 tb/tb_axioma_eeprom_ctrl_v2.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axioma_eeprom_pkg.sv
// Shared definitions for the EEPROM controller: register map, EECR bit positions,
// programming modes and FSM state encodings.
// Pure declarations; no logic, no latency, no flow control.
package axioma_eeprom_pkg;

    // I/O register addresses
    localparam logic [5:0] ADDR_EECR  = 6'h1F;
    localparam logic [5:0] ADDR_EEDR  = 6'h20;
    localparam logic [5:0] ADDR_EEARL = 6'h21;
    localparam logic [5:0] ADDR_EEARH = 6'h22;

    // EECR bit indices
    localparam int EECR_EERE  = 0;
    localparam int EECR_EEPE  = 1;
    localparam int EECR_EEMPE = 2;
    localparam int EECR_EERIE = 3;
    localparam int EECR_EEPM0 = 4;
    localparam int EECR_EEPM1 = 5;

    // Programming modes held in EEPM[1:0]
    typedef enum logic [1:0] {
        EEPM_ERASE_WRITE = 2'b00,
        EEPM_ERASE_ONLY  = 2'b01,
        EEPM_WRITE_ONLY  = 2'b10,
        EEPM_RESERVED    = 2'b11
    } eepm_e;

    // Controller FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_ERASE = 3'd2,
        ST_PROG  = 3'd3
    } state_e;

    // Byte stored by the program phase: write-only mode can only clear bits.
    function automatic logic [7:0] prog_result(input eepm_e mode, input logic [7:0] old_byte,
                                               input logic [7:0] new_byte);
        return (mode == EEPM_WRITE_ONLY) ? (old_byte & new_byte) : new_byte;
    endfunction

endpackage

// File: rtl/axioma_eeprom_array.sv
// Byte-wide non-volatile array model: synchronous write port, combinational read port.
// Read has zero latency; write lands on the clock edge with wr_en high.
// No backpressure; contents are deliberately outside the reset domain.
module axioma_eeprom_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_dat,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_dat
);

    // Cells hold the complement of the stored byte so an all-zero power-up
    // state presents as an erased (0xFF) array without any reset or init sweep.
    logic [7:0] mem_inv [2**ADDR_W];

    // Single write port, committed on the final cycle of an erase or program.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_inv[wr_addr] <= ~wr_dat;
        end
    end

    assign rd_dat = ~mem_inv[rd_addr];

endmodule

// File: rtl/axioma_eeprom_ctrl_v2.sv
// ATmega328P-style EEPROM controller: EECR/EEDR/EEAR registers, EEMPE arming window, erase/program/read FSM.
// Register reads are combinational; a read halts the CPU READ_CYCLES clocks, erase/program run ERASE/WRITE_CYCLES.
// Backpressure is cpu_halt (read, and WRITE_HALT_CYCLES after EEPE); register writes are dropped while busy.
module axioma_eeprom_ctrl_v2
    import axioma_eeprom_pkg::*;
#(
    parameter int ADDR_W            = 10,
    parameter int ERASE_CYCLES      = 3400,
    parameter int WRITE_CYCLES      = 3400,
    parameter int READ_CYCLES       = 4,
    parameter int WRITE_HALT_CYCLES = 2,
    parameter int EEMPE_WINDOW      = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] io_addr,
    input  logic [7:0] io_data_in,
    output logic [7:0] io_data_out,
    input  logic       io_read,
    input  logic       io_write,
    output logic       eeprom_irq,
    output logic       cpu_halt,
    output logic       busy,
    output logic [7:0] debug_state
);

    localparam int         HW          = ADDR_W - 8;
    localparam logic [15:0] ERASE_LAST = 16'(ERASE_CYCLES - 1);
    localparam logic [15:0] WRITE_LAST = 16'(WRITE_CYCLES - 1);
    localparam logic [15:0] READ_LAST  = 16'(READ_CYCLES - 1);
    localparam logic [15:0] WIN_LOAD   = 16'(EEMPE_WINDOW);
    localparam logic [15:0] HALT_LOAD  = 16'(WRITE_HALT_CYCLES);

    // Register file and FSM state
    logic [7:0]        eedr_q, eedr_d;
    logic [7:0]        eearl_q, eearl_d;
    logic [HW-1:0]     eearh_q, eearh_d;
    eepm_e             eepm_q, eepm_d;
    logic              eerie_q, eerie_d;
    logic              eempe_q, eempe_d;
    logic [15:0]       win_cnt_q, win_cnt_d;
    logic [15:0]       halt_cnt_q, halt_cnt_d;
    logic [15:0]       phase_cnt_q, phase_cnt_d;
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
    logic [7:0]        lat_dat_q, lat_dat_d;
    eepm_e             lat_mode_q, lat_mode_d;

    logic [ADDR_W-1:0] eear;
    logic              wr_eecr, wr_eedr, wr_eearl, wr_eearh;
    logic              idle, start_read, accept;
    eepm_e             wr_mode;
    logic              rd_done;
    logic              arr_we;
    logic [7:0]        arr_wdat, arr_rdat;
    logic [ADDR_W-1:0] arr_raddr;

    assign eear     = {eearh_q, eearl_q};
    assign wr_eecr  = io_write && (io_addr == ADDR_EECR);
    assign wr_eedr  = io_write && (io_addr == ADDR_EEDR);
    assign wr_eearl = io_write && (io_addr == ADDR_EEARL);
    assign wr_eearh = io_write && (io_addr == ADDR_EEARH);
    assign idle     = (state_q == ST_IDLE);
    assign busy     = (state_q == ST_ERASE) || (state_q == ST_PROG);
    assign wr_mode  = eepm_e'(io_data_in[EECR_EEPM1:EECR_EEPM0]);

    // A read request takes priority, so EEPE is only honoured when EERE is clear;
    // EEMPE must already be armed, which rules out setting both in one write.
    assign start_read = wr_eecr && io_data_in[EECR_EERE] && idle;
    assign accept     = wr_eecr && io_data_in[EECR_EEPE] && !io_data_in[EECR_EEMPE]
                        && !io_data_in[EECR_EERE] && eempe_q && idle
                        && (wr_mode != EEPM_RESERVED);

    // Reads address the live EEAR; erase/program use the address latched at EEPE.
    assign arr_raddr = (state_q == ST_READ) ? eear : lat_addr_q;

    axioma_eeprom_array #(.ADDR_W(ADDR_W)) u_array (
        .clk     (clk),
        .wr_en   (arr_we),
        .wr_addr (lat_addr_q),
        .wr_dat  (arr_wdat),
        .rd_addr (arr_raddr),
        .rd_dat  (arr_rdat)
    );

    // Operation sequencing: phase counting, operand latching and the single array write.
    always_comb begin
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q;
        lat_addr_d  = lat_addr_q;
        lat_dat_d   = lat_dat_q;
        lat_mode_d  = lat_mode_q;
        arr_we      = 1'b0;
        arr_wdat    = 8'h00;
        rd_done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                phase_cnt_d = 16'd0;
                if (start_read) begin
                    state_d = ST_READ;
                end else if (accept) begin
                    lat_addr_d = eear;
                    lat_dat_d  = eedr_q;
                    lat_mode_d = wr_mode;
                    state_d    = (wr_mode == EEPM_WRITE_ONLY) ? ST_PROG : ST_ERASE;
                end
            end
            ST_READ: begin
                if (phase_cnt_q == READ_LAST) begin
                    rd_done     = 1'b1;
                    phase_cnt_d = 16'd0;
                    state_d     = ST_IDLE;
                end else begin
                    phase_cnt_d = phase_cnt_q + 16'd1;
                end
            end
            ST_ERASE: begin
                if (phase_cnt_q == ERASE_LAST) begin
                    phase_cnt_d = 16'd0;
                    if (lat_mode_q == EEPM_ERASE_ONLY) begin
                        arr_we   = 1'b1;
                        arr_wdat = 8'hFF;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d = ST_PROG;
                    end
                end else begin
                    phase_cnt_d = phase_cnt_q + 16'd1;
                end
            end
            ST_PROG: begin
                if (phase_cnt_q == WRITE_LAST) begin
                    arr_we      = 1'b1;
                    arr_wdat    = prog_result(lat_mode_q, arr_rdat, lat_dat_q);
                    phase_cnt_d = 16'd0;
                    state_d     = ST_IDLE;
                end else begin
                    phase_cnt_d = phase_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                phase_cnt_d = 16'd0;
            end
        endcase
    end

    // CPU-visible registers, EEMPE window and post-EEPE halt countdown.
    always_comb begin
        eedr_d     = eedr_q;
        eearl_d    = eearl_q;
        eearh_d    = eearh_q;
        eepm_d     = eepm_q;
        eerie_d    = eerie_q;
        eempe_d    = eempe_q;
        win_cnt_d  = win_cnt_q;
        halt_cnt_d = halt_cnt_q;

        if (win_cnt_q != 16'd0) begin
            win_cnt_d = win_cnt_q - 16'd1;
            if (win_cnt_q == 16'd1) begin
                eempe_d = 1'b0;
            end
        end
        if (halt_cnt_q != 16'd0) begin
            halt_cnt_d = halt_cnt_q - 16'd1;
        end

        if (wr_eecr) begin
            eerie_d = io_data_in[EECR_EERIE];
            if (!busy) begin
                eepm_d = wr_mode;
            end
            if (io_data_in[EECR_EEMPE]) begin
                eempe_d   = 1'b1;
                win_cnt_d = WIN_LOAD;
            end
        end
        if (accept) begin
            eempe_d    = 1'b0;
            win_cnt_d  = 16'd0;
            halt_cnt_d = HALT_LOAD;
        end

        if (wr_eedr && !busy) begin
            eedr_d = io_data_in;
        end
        if (wr_eearl && !busy) begin
            eearl_d = io_data_in;
        end
        if (wr_eearh && !busy) begin
            eearh_d = io_data_in[HW-1:0];
        end
        if (rd_done) begin
            eedr_d = arr_rdat;
        end
    end

    // State register; array contents are not in this reset domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eedr_q      <= 8'h00;
            eearl_q     <= 8'h00;
            eearh_q     <= '0;
            eepm_q      <= EEPM_ERASE_WRITE;
            eerie_q     <= 1'b0;
            eempe_q     <= 1'b0;
            win_cnt_q   <= 16'd0;
            halt_cnt_q  <= 16'd0;
            phase_cnt_q <= 16'd0;
            state_q     <= ST_IDLE;
            lat_addr_q  <= '0;
            lat_dat_q   <= 8'h00;
            lat_mode_q  <= EEPM_ERASE_WRITE;
        end else begin
            eedr_q      <= eedr_d;
            eearl_q     <= eearl_d;
            eearh_q     <= eearh_d;
            eepm_q      <= eepm_d;
            eerie_q     <= eerie_d;
            eempe_q     <= eempe_d;
            win_cnt_q   <= win_cnt_d;
            halt_cnt_q  <= halt_cnt_d;
            phase_cnt_q <= phase_cnt_d;
            state_q     <= state_d;
            lat_addr_q  <= lat_addr_d;
            lat_dat_q   <= lat_dat_d;
            lat_mode_q  <= lat_mode_d;
        end
    end

    assign cpu_halt    = (state_q == ST_READ) || (halt_cnt_q != 16'd0);
    assign eeprom_irq  = eerie_q && idle;
    assign debug_state = {state_q, busy, eempe_q, 3'b000};

    // I/O read mux; unmapped addresses and idle strobe return zero.
    always_comb begin
        io_data_out = 8'h00;
        if (io_read) begin
            case (io_addr)
                ADDR_EECR:  io_data_out = {2'b00, eepm_q, eerie_q, eempe_q, busy, 1'b0};
                ADDR_EEDR:  io_data_out = eedr_q;
                ADDR_EEARL: io_data_out = eearl_q;
                ADDR_EEARH: io_data_out = {{(16 - ADDR_W){1'b0}}, eearh_q};
                default:    io_data_out = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_axioma_eeprom_ctrl_v2.sv
// Self-checking bench for the EEPROM controller with short erase/write timing.
// Each access completes in one clock; operations are polled to completion with cycle bounds.
// A byte-array reference model tracks expected array contents.
module tb_axioma_eeprom_ctrl_v2;
    import axioma_eeprom_pkg::*;

    localparam int AW = 10;
    localparam int EC = 20;
    localparam int WC = 30;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] io_addr = 6'h00;
    logic [7:0] io_data_in = 8'h00;
    logic [7:0] io_data_out;
    logic       io_read = 1'b0;
    logic       io_write = 1'b0;
    logic       eeprom_irq, cpu_halt, busy;
    logic [7:0] debug_state;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] mdl [1024];

    axioma_eeprom_ctrl_v2 #(
        .ADDR_W(AW), .ERASE_CYCLES(EC), .WRITE_CYCLES(WC),
        .READ_CYCLES(4), .WRITE_HALT_CYCLES(2), .EEMPE_WINDOW(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .io_addr(io_addr), .io_data_in(io_data_in),
        .io_data_out(io_data_out), .io_read(io_read), .io_write(io_write),
        .eeprom_irq(eeprom_irq), .cpu_halt(cpu_halt), .busy(busy), .debug_state(debug_state)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected array byte after an operation, straight from the mode rules.
    function automatic logic [7:0] exp_byte(input logic [1:0] mode, input logic [7:0] old_b,
                                            input logic [7:0] dat);
        case (mode)
            2'b00:   return dat;
            2'b01:   return 8'hFF;
            default: return old_b & dat;
        endcase
    endfunction

    function automatic int exp_busy(input logic [1:0] mode);
        case (mode)
            2'b00:   return EC + WC;
            2'b01:   return EC;
            default: return WC;
        endcase
    endfunction

    // Drivers: called in the low phase of clk; a write is sampled by the next rising edge.
    task automatic io_wr(input logic [5:0] a, input logic [7:0] d);
        io_addr = a; io_data_in = d; io_write = 1'b1;
        @(negedge clk);
        io_write = 1'b0; io_addr = 6'h00; io_data_in = 8'h00;
    endtask

    task automatic io_rd(input logic [5:0] a, output logic [7:0] d);
        io_addr = a; io_read = 1'b1;
        #1;
        d = io_data_out;
        io_read = 1'b0; io_addr = 6'h00;
    endtask

    task automatic set_eear(input logic [9:0] a);
        io_wr(ADDR_EEARL, a[7:0]);
        io_wr(ADDR_EEARH, {6'b0, a[9:8]});
    endtask

    task automatic wait_idle(output int busy_n, output int halt_n, output bit irq_in_busy,
                             output bit tout);
        bit done = 1'b0;
        busy_n = 0; halt_n = 0; irq_in_busy = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            if (!busy && !cpu_halt) begin
                done = 1'b1;
            end else begin
                if (busy) busy_n++;
                if (cpu_halt) halt_n++;
                if (busy && eeprom_irq) irq_in_busy = 1'b1;
                @(negedge clk);
            end
        end
        tout = !done;
    endtask

    task automatic do_read(input logic [9:0] a, output logic [7:0] d, output int halt_n,
                           output bit tout);
        int b; bit ib;
        set_eear(a);
        io_wr(ADDR_EECR, 8'h01);
        wait_idle(b, halt_n, ib, tout);
        io_rd(ADDR_EEDR, d);
    endtask

    task automatic do_write(input logic [9:0] a, input logic [7:0] dat, input logic [1:0] mode,
                            input logic eerie, output int busy_n, output int halt_n,
                            output bit irq_in_busy, output bit tout);
        set_eear(a);
        io_wr(ADDR_EEDR, dat);
        io_wr(ADDR_EECR, {2'b00, mode, eerie, 3'b100});
        io_wr(ADDR_EECR, {2'b00, mode, eerie, 3'b010});
        wait_idle(busy_n, halt_n, irq_in_busy, tout);
        if (!tout) mdl[a] = exp_byte(mode, mdl[a], dat);
    endtask

    task automatic test_reset();
        logic [7:0] r;
        repeat (2) @(negedge clk);
        n_vec++; if ({busy, cpu_halt, eeprom_irq} !== 3'b000) begin n_err++;
            $display("FAIL reset_outputs: busy/halt/irq=%b expected 000", {busy, cpu_halt, eeprom_irq}); end
        n_vec++; if (debug_state !== 8'h00) begin n_err++;
            $display("FAIL reset_debug: got %h expected 00", debug_state); end
        reset_n = 1'b1;
        @(negedge clk);
        io_rd(ADDR_EECR, r);
        n_vec++; if (r !== 8'h00) begin n_err++; $display("FAIL reset_eecr: got %h expected 00", r); end
        io_rd(ADDR_EEDR, r);
        n_vec++; if (r !== 8'h00) begin n_err++; $display("FAIL reset_eedr: got %h expected 00", r); end
        io_rd(ADDR_EEARL, r);
        n_vec++; if (r !== 8'h00) begin n_err++; $display("FAIL reset_eearl: got %h expected 00", r); end
        io_rd(6'h10, r);
        n_vec++; if (r !== 8'h00) begin n_err++; $display("FAIL unmapped_read: got %h expected 00", r); end
    endtask

    task automatic test_fresh_read();
        logic [7:0] r; int h; bit t;
        do_read(10'h3FF, r, h, t);
        n_vec++; if (t !== 1'b0) begin n_err++; $display("FAIL read_timeout: op never finished"); end
        n_vec++; if (h !== 4) begin n_err++; $display("FAIL read_halt: got %0d clocks expected 4", h); end
        n_vec++; if (r !== 8'hFF) begin n_err++; $display("FAIL fresh_read: got %h expected ff", r); end
        io_rd(ADDR_EECR, r);
        n_vec++; if (r !== 8'h00) begin n_err++; $display("FAIL eecr_after_read: got %h expected 00", r); end
        io_wr(ADDR_EEARH, 8'hFF);
        io_rd(ADDR_EEARH, r);
        n_vec++; if (r !== 8'h03) begin n_err++; $display("FAIL eearh_unused: got %h expected 03", r); end
    endtask

    task automatic test_erase_write();
        int b, h; bit ib, t; logic [7:0] r;
        do_write(10'h155, 8'hA5, 2'b00, 1'b1, b, h, ib, t);
        n_vec++; if (t !== 1'b0) begin n_err++; $display("FAIL ew_timeout: op never finished"); end
        n_vec++; if (b !== EC + WC) begin n_err++; $display("FAIL ew_busy: got %0d clocks expected %0d", b, EC + WC); end
        n_vec++; if (h !== 2) begin n_err++; $display("FAIL ew_halt: got %0d clocks expected 2", h); end
        n_vec++; if (ib !== 1'b0) begin n_err++; $display("FAIL ew_irq_busy: irq seen during busy"); end
        n_vec++; if (eeprom_irq !== 1'b1) begin n_err++; $display("FAIL ew_irq_idle: got %b expected 1", eeprom_irq); end
        io_wr(ADDR_EECR, 8'h00);
        n_vec++; if (eeprom_irq !== 1'b0) begin n_err++; $display("FAIL irq_clear: got %b expected 0", eeprom_irq); end
        do_read(10'h155, r, h, t);
        n_vec++; if (r !== mdl[10'h155]) begin n_err++; $display("FAIL ew_readback: got %h expected %h", r, mdl[10'h155]); end
    endtask

    task automatic test_window();
        logic [7:0] r; int b, h; bit ib, t;
        set_eear(10'h0AA);
        io_wr(ADDR_EEDR, 8'h12);
        io_wr(ADDR_EECR, 8'h04);
        io_rd(ADDR_EECR, r);
        n_vec++; if (r !== 8'h04) begin n_err++; $display("FAIL eempe_set: got %h expected 04", r); end
        repeat (5) @(negedge clk);
        io_wr(ADDR_EECR, 8'h02);
        repeat (2) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL late_eepe: busy %b expected 0", busy); end
        io_wr(ADDR_EECR, 8'h06);
        repeat (2) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL combined_eepe: busy %b expected 0", busy); end
        repeat (6) @(negedge clk);
        // Four clocks after arming: window has closed
        io_wr(ADDR_EECR, 8'h04);
        repeat (4) @(negedge clk);
        io_wr(ADDR_EECR, 8'h02);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL window_edge_closed: busy %b expected 0", busy); end
        do_read(10'h0AA, r, h, t);
        n_vec++; if (r !== mdl[10'h0AA]) begin n_err++; $display("FAIL window_unchanged: got %h expected %h", r, mdl[10'h0AA]); end
        // Three clocks after arming: last open cycle
        io_wr(ADDR_EEDR, 8'h12);
        io_wr(ADDR_EECR, 8'h04);
        repeat (3) @(negedge clk);
        io_wr(ADDR_EECR, 8'h02);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL window_edge_open: busy %b expected 1", busy); end
        wait_idle(b, h, ib, t);
        if (!t) mdl[10'h0AA] = exp_byte(2'b00, mdl[10'h0AA], 8'h12);
        do_read(10'h0AA, r, h, t);
        n_vec++; if (r !== mdl[10'h0AA]) begin n_err++; $display("FAIL window_write: got %h expected %h", r, mdl[10'h0AA]); end
    endtask

    task automatic test_write_only();
        int b, h; bit ib, t; logic [7:0] r;
        do_write(10'h2C3, 8'hF0, 2'b00, 1'b0, b, h, ib, t);
        do_write(10'h2C3, 8'h3C, 2'b10, 1'b0, b, h, ib, t);
        n_vec++; if (b !== WC) begin n_err++; $display("FAIL wo_busy: got %0d clocks expected %0d", b, WC); end
        do_read(10'h2C3, r, h, t);
        n_vec++; if (r !== 8'h30) begin n_err++; $display("FAIL wo_and: got %h expected 30", r); end
        do_write(10'h2C3, 8'h00, 2'b01, 1'b0, b, h, ib, t);
        n_vec++; if (b !== EC) begin n_err++; $display("FAIL eo_busy: got %0d clocks expected %0d", b, EC); end
        do_read(10'h2C3, r, h, t);
        n_vec++; if (r !== 8'hFF) begin n_err++; $display("FAIL eo_result: got %h expected ff", r); end
    endtask

    task automatic test_busy_protect();
        logic [9:0] a; logic [7:0] d, r; int b, h; bit ib, t;
        a = 10'($urandom_range(1, 1023));
        d = 8'($urandom);
        set_eear(a);
        io_wr(ADDR_EEDR, d);
        io_wr(ADDR_EECR, 8'h04);
        io_wr(ADDR_EECR, 8'h02);
        n_vec++; if (debug_state !== 8'h50) begin n_err++; $display("FAIL debug_erase: got %h expected 50", debug_state); end
        io_wr(ADDR_EEARL, 8'h00);
        io_wr(ADDR_EEDR, 8'h11);
        io_wr(ADDR_EECR, 8'h01);
        wait_idle(b, h, ib, t);
        n_vec++; if (b + 3 !== EC + WC) begin n_err++; $display("FAIL bp_busy: got %0d clocks expected %0d", b + 3, EC + WC); end
        io_rd(ADDR_EEARL, r);
        n_vec++; if (r !== a[7:0]) begin n_err++; $display("FAIL bp_eearl: got %h expected %h", r, a[7:0]); end
        io_rd(ADDR_EEDR, r);
        n_vec++; if (r !== d) begin n_err++; $display("FAIL bp_eedr: got %h expected %h", r, d); end
        if (!t) mdl[a] = exp_byte(2'b00, mdl[a], d);
        do_read(a, r, h, t);
        n_vec++; if (r !== mdl[a]) begin n_err++; $display("FAIL bp_readback: got %h expected %h", r, mdl[a]); end
        do_read(10'h000 | {a[9:8], 8'h00}, r, h, t);
        n_vec++; if (r !== mdl[{a[9:8], 8'h00}]) begin n_err++;
            $display("FAIL bp_other_addr: got %h expected %h", r, mdl[{a[9:8], 8'h00}]); end
    endtask

    task automatic test_random();
        logic [9:0] a; logic [7:0] d, r; logic [1:0] m; int b, h; bit ib, t;
        for (int k = 0; k < 10; k++) begin
            a = 10'($urandom);
            d = 8'($urandom);
            m = 2'($urandom_range(0, 2));
            do_write(a, d, m, 1'b0, b, h, ib, t);
            n_vec++; if (b !== exp_busy(m)) begin n_err++;
                $display("FAIL rand_busy[%0d]: mode %b got %0d clocks expected %0d", k, m, b, exp_busy(m)); end
            do_read(a, r, h, t);
            n_vec++; if (r !== mdl[a]) begin n_err++;
                $display("FAIL rand_data[%0d]: addr %h mode %b got %h expected %h", k, a, m, r, mdl[a]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] a; logic [7:0] pre, r; int h; bit t;
        a = 10'h2C3;
        pre = mdl[a];
        set_eear(a);
        io_wr(ADDR_EEDR, 8'h0F);
        io_wr(ADDR_EECR, 8'h2C);
        io_wr(ADDR_EECR, 8'h2A);
        repeat (10) @(negedge clk);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rm_started: busy %b expected 1", busy); end
        reset_n = 1'b0;
        #1;
        n_vec++; if ({busy, cpu_halt, eeprom_irq} !== 3'b000) begin n_err++;
            $display("FAIL rm_outputs: busy/halt/irq=%b expected 000", {busy, cpu_halt, eeprom_irq}); end
        n_vec++; if (debug_state !== 8'h00) begin n_err++; $display("FAIL rm_debug: got %h expected 00", debug_state); end
        io_rd(ADDR_EECR, r);
        n_vec++; if (r !== 8'h00) begin n_err++; $display("FAIL rm_eecr: got %h expected 00", r); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        repeat (WC) @(negedge clk);
        do_read(a, r, h, t);
        n_vec++; if (r !== pre) begin n_err++; $display("FAIL rm_array: got %h expected %h", r, pre); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mdl[i] = 8'hFF;
        test_reset();
        test_fresh_read();
        test_erase_write();
        test_window();
        test_write_only();
        test_busy_protect();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
